// File: rtl/cmd_dispatch_pkg.sv
// Shared constants and types for the command dispatcher: frame bytes,
// legal address/request windows and the dispatcher FSM state type.
package cmd_dispatch_pkg;

    localparam logic [7:0] FRAME_HDR   = 8'hFF;
    localparam logic [7:0] FRAME_TRL   = 8'h7F;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEE;

    localparam logic [7:0] ADDR_MIN = 8'h01;
    localparam logic [7:0] ADDR_MAX = 8'h20;
    localparam logic [7:0] REQ_MIN  = 8'h81;
    localparam logic [7:0] REQ_MAX  = 8'h88;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    function automatic logic pair_valid(input logic [7:0] addr, input logic [7:0] req);
        return (addr >= ADDR_MIN) && (addr <= ADDR_MAX) &&
               (req  >= REQ_MIN)  && (req  <= REQ_MAX);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: show-ahead FIFO with wrap-around pointers and an occupancy
// count. A push into a full queue is accepted only when a pop happens in the
// same cycle, so occupancy stays unchanged in that case.
module cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // storage write; contents need no reset since empty gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: captures {End,Req} pairs from the frame parser, queues
// legal ones, issues them one at a time to the sensor interface and frames
// each response as FF addr code data 7F toward the UART transmitter.
// Optional feature macro: CMD_DISPATCH_TIMEOUT_EN (response timeout in WAIT).
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | nothing in flight; pops the queue head when available
//   ST_ISSUE | sns_valid high with current command, waiting sns_ready
//   ST_WAIT  | command accepted, waiting for the sensor response
//   ST_SEND  | streaming the 5-byte response frame to the UART
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] End,
    input  logic [7:0] Req,
    output logic [7:0] sns_addr,
    output logic [7:0] sns_req,
    output logic       sns_valid,
    input  logic       sns_ready,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_code,
    input  logic [7:0] rsp_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overflow,
    output logic       bad_cmd
);

    if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("cmd_dispatch: FIFO_DEPTH and TIMEOUT_CYCLES must be >= 2");
    end

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pair_cur;
    logic [15:0] pair_prev;
    logic        capture;
    logic        cmd_ok;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_head;
    logic [15:0] cur_cmd;
    logic [7:0]  rsp_code_q;
    logic [7:0]  rsp_data_q;
    logic [2:0]  byte_idx;
    logic        timeout_hit;

    assign pair_cur  = {End, Req};
    assign capture   = (pair_cur != 16'h0000) && (pair_cur != pair_prev);
    assign cmd_ok    = pair_valid(End, Req);
    assign fifo_push = capture && cmd_ok;

    cmd_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (pair_cur),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wait_cnt;

    // cycles spent in WAIT; restarts from zero on every entry
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_WAIT) wait_cnt <= '0;
        else                           wait_cnt <= wait_cnt + TW'(1);
    end

    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // edge detection on the parser pair and the sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_prev <= '0;
            overflow  <= 1'b0;
            bad_cmd   <= 1'b0;
        end else begin
            pair_prev <= pair_cur;
            if (capture && !cmd_ok)                     bad_cmd  <= 1'b1;
            if (fifo_push && fifo_full && !fifo_pop)    overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // current command, latched response and frame byte index
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_cmd    <= '0;
            rsp_code_q <= '0;
            rsp_data_q <= '0;
            byte_idx   <= '0;
        end else begin
            if (fifo_pop) cur_cmd <= fifo_head;
            if (state_q == ST_WAIT) begin
                if (rsp_valid) begin
                    rsp_code_q <= rsp_code;
                    rsp_data_q <= rsp_data;
                end else if (timeout_hit) begin
                    rsp_code_q <= RSP_TIMEOUT;
                    rsp_data_q <= 8'h00;
                end
            end
            if (state_q == ST_SEND) begin
                if (tx_ready) byte_idx <= (byte_idx == 3'd4) ? 3'd0 : byte_idx + 3'd1;
            end else begin
                byte_idx <= 3'd0;
            end
        end
    end

    // next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        sns_valid = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sns_valid = 1'b1;
                if (sns_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_valid || timeout_hit) state_d = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                case (byte_idx)
                    3'd0:    tx_data = FRAME_HDR;
                    3'd1:    tx_data = cur_cmd[15:8];
                    3'd2:    tx_data = rsp_code_q;
                    3'd3:    tx_data = rsp_data_q;
                    default: tx_data = FRAME_TRL;
                endcase
                if (tx_ready && byte_idx == 3'd4) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sns_addr = cur_cmd[15:8];
    assign sns_req  = cur_cmd[7:0];
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch. Build with +define+CMD_DISPATCH_TIMEOUT_EN
// to also exercise the response timeout (TIMEOUT_CYCLES set to 100 here).
module tb_cmd_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] End;
    logic [7:0] Req;
    logic [7:0] sns_addr;
    logic [7:0] sns_req;
    logic       sns_valid;
    logic       sns_ready;
    logic       rsp_valid;
    logic [7:0] rsp_code;
    logic [7:0] rsp_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       overflow;
    logic       bad_cmd;

    int n_cmp = 0;
    int n_bad = 0;

    cmd_dispatch #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .End       (End),
        .Req       (Req),
        .sns_addr  (sns_addr),
        .sns_req   (sns_req),
        .sns_valid (sns_valid),
        .sns_ready (sns_ready),
        .rsp_valid (rsp_valid),
        .rsp_code  (rsp_code),
        .rsp_data  (rsp_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .overflow  (overflow),
        .bad_cmd   (bad_cmd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        End = 8'h00; Req = 8'h00;
        sns_ready = 1'b0; rsp_valid = 1'b0; rsp_code = 8'h00; rsp_data = 8'h00;
        tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic put_pair(input logic [7:0] a, input logic [7:0] r);
        End = a; Req = r;
        tick();
        End = 8'h00; Req = 8'h00;
    endtask

    // accept a frame with tx_ready high and compare it to FF addr code data 7F
    task automatic check_frame(input logic [7:0] ea, input logic [7:0] ec, input logic [7:0] ed);
        logic [7:0] got [5];
        logic [7:0] exp [5];
        int nb;
        int n;
        exp[0] = 8'hFF; exp[1] = ea; exp[2] = ec; exp[3] = ed; exp[4] = 8'h7F;
        for (int i = 0; i < 5; i++) got[i] = 8'hXX;
        nb = 0;
        n = 0;
        tx_ready = 1'b1;
        while (nb < 5 && n < 40) begin
            if (tx_valid) begin
                got[nb] = tx_data;
                nb++;
            end
            tick();
            n++;
        end
        tx_ready = 1'b0;
        check_val("frame_len", 32'(nb), 32'd5);
        for (int i = 0; i < 5; i++) check_val($sformatf("tx_byte%0d", i), 32'(got[i]), 32'(exp[i]));
    endtask

    // complete one command: wait for issue, accept it, respond, check the frame
    task automatic serve(input logic [7:0] ea, input logic [7:0] er,
                         input logic [7:0] code, input logic [7:0] data);
        int n;
        n = 0;
        sns_ready = 1'b1;
        while (!sns_valid && n < 20) begin
            tick();
            n++;
        end
        check_val("issue_seen", 32'(sns_valid), 32'd1);
        check_val("sns_addr", 32'(sns_addr), 32'(ea));
        check_val("sns_req", 32'(sns_req), 32'(er));
        tick();
        sns_ready = 1'b0;
        check_val("issue_done", 32'(sns_valid), 32'd0);
        rsp_code = code; rsp_data = data; rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check_frame(ea, code, data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int first;
        logic [7:0] pa;
        logic [7:0] pr;
        int n;

        End = 8'h00; Req = 8'h00; rst = 1'b1;
        sns_ready = 1'b0; rsp_valid = 1'b0; rsp_code = 8'h00; rsp_data = 8'h00;
        tx_ready = 1'b0;

        do_reset();
        check_val("rst_sns_valid", 32'(sns_valid), 32'd0);
        check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_val("rst_sns_addr", 32'(sns_addr), 32'd0);
        check_val("rst_sns_req", 32'(sns_req), 32'd0);
        check_val("rst_tx_data", 32'(tx_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_bad_cmd", 32'(bad_cmd), 32'd0);

        // legal pair held ten cycles: one issue, two cycles after capture
        sns_ready = 1'b1;
        End = 8'h05; Req = 8'h82;
        pulses = 0; first = -1; pa = 8'h00; pr = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) begin End = 8'h00; Req = 8'h00; end
            if (sns_valid) begin
                if (first < 0) begin first = i; pa = sns_addr; pr = sns_req; end
                pulses++;
            end
            tick();
        end
        sns_ready = 1'b0;
        check_val("issue_pulses", 32'(pulses), 32'd1);
        check_val("issue_latency", 32'(first), 32'd2);
        check_val("issue_addr", 32'(pa), 32'h05);
        check_val("issue_req", 32'(pr), 32'h82);

        rsp_code = 8'h01; rsp_data = 8'h3C; rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check_frame(8'h05, 8'h01, 8'h3C);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_tx_valid", 32'(tx_valid), 32'd0);

        // out-of-range address, then out-of-range request
        do_reset();
        sns_ready = 1'b1;
        put_pair(8'h21, 8'h82);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (sns_valid) pulses++;
            tick();
        end
        check_val("bad_addr_issue", 32'(pulses), 32'd0);
        check_val("bad_addr_flag", 32'(bad_cmd), 32'd1);
        check_val("bad_addr_busy", 32'(busy), 32'd0);

        do_reset();
        sns_ready = 1'b1;
        put_pair(8'h01, 8'h89);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (sns_valid) pulses++;
            tick();
        end
        check_val("bad_req_issue", 32'(pulses), 32'd0);
        check_val("bad_req_flag", 32'(bad_cmd), 32'd1);

        // upper corner of the legal window
        do_reset();
        put_pair(8'h20, 8'h88);
        serve(8'h20, 8'h88, 8'h5A, 8'h00);
        check_val("corner_bad_cmd", 32'(bad_cmd), 32'd0);

        // six commands against a blocked sensor: five kept, sixth overflows
        do_reset();
        End = 8'h01; Req = 8'h81; tick();
        End = 8'h02; Req = 8'h82; tick();
        End = 8'h03; Req = 8'h83; tick();
        End = 8'h04; Req = 8'h84; tick();
        End = 8'h05; Req = 8'h85; tick();
        End = 8'h06; Req = 8'h86; tick();
        End = 8'h00; Req = 8'h00; tick();
        check_val("ovf_flag", 32'(overflow), 32'd1);
        check_val("ovf_bad_cmd", 32'(bad_cmd), 32'd0);
        serve(8'h01, 8'h81, 8'h10, 8'h11);
        serve(8'h02, 8'h82, 8'h20, 8'h22);
        serve(8'h03, 8'h83, 8'h30, 8'h33);
        serve(8'h04, 8'h84, 8'h40, 8'h44);
        serve(8'h05, 8'h85, 8'h50, 8'h55);
        tick();
        tick();
        check_val("ovf_drained_busy", 32'(busy), 32'd0);
        check_val("ovf_sticky", 32'(overflow), 32'd1);

        // reset in the middle of a frame
        do_reset();
        put_pair(8'h21, 8'h82);
        put_pair(8'h07, 8'h83);
        sns_ready = 1'b1;
        n = 0;
        while (!sns_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        sns_ready = 1'b0;
        put_pair(8'h08, 8'h84);
        rsp_code = 8'hAB; rsp_data = 8'hCD; rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
        check_val("mid_tx_valid", 32'(tx_valid), 32'd1);
        check_val("mid_tx_byte2", 32'(tx_data), 32'hAB);
        check_val("mid_bad_cmd", 32'(bad_cmd), 32'd1);
        rst = 1'b1;
        tick();
        check_val("mrst_tx_valid", 32'(tx_valid), 32'd0);
        check_val("mrst_tx_data", 32'(tx_data), 32'd0);
        check_val("mrst_busy", 32'(busy), 32'd0);
        check_val("mrst_bad_cmd", 32'(bad_cmd), 32'd0);
        check_val("mrst_overflow", 32'(overflow), 32'd0);
        check_val("mrst_sns_addr", 32'(sns_addr), 32'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        sns_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx_valid || sns_valid) pulses++;
            tick();
        end
        tx_ready = 1'b0;
        sns_ready = 1'b0;
        check_val("mrst_quiet", 32'(pulses), 32'd0);

`ifdef CMD_DISPATCH_TIMEOUT_EN
        // no response: timeout frame starts 100 cycles into WAIT
        do_reset();
        put_pair(8'h09, 8'h84);
        sns_ready = 1'b1;
        n = 0;
        while (!sns_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        sns_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 300) begin
            tick();
            n++;
        end
        check_val("timeout_cycles", 32'(n), 32'd100);
        check_frame(8'h09, 8'hEE, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
